// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a downstream JK flip-flop: queues hold/reset/set/toggle
// commands, replays each as a one-cycle j/k pulse, and checks the fed-back q.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       j,
    output logic       k,
    input  logic       q_fb,
    output logic       exp_q,
    output logic       mismatch,
    output logic       busy,
    output logic [7:0] cmd_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    cur_cmd_q, cur_cmd_d;
    logic          j_q, j_d;
    logic          k_q, k_d;
    logic          exp_state_q, exp_state_d;
    logic          mismatch_q, mismatch_d;
    logic [7:0]    cmd_count_q, cmd_count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = cmd_valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cur_cmd_d   = cur_cmd_q;
        j_d         = 1'b0;
        k_d         = 1'b0;
        exp_state_d = exp_state_q;
        mismatch_d  = mismatch_q;
        cmd_count_d = cmd_count_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    cur_cmd_d = mem_q[rd_ptr_q];
                    j_d       = mem_q[rd_ptr_q][1];
                    k_d       = mem_q[rd_ptr_q][0];
                    state_d   = S_DRIVE;
                end
            end
            S_DRIVE: begin
                case (cur_cmd_q)
                    2'b01:   exp_state_d = 1'b0;
                    2'b10:   exp_state_d = 1'b1;
                    2'b11:   exp_state_d = ~exp_state_q;
                    default: exp_state_d = exp_state_q;
                endcase
                state_d = S_CHECK;
            end
            S_CHECK: begin
                // Resync on a fault so a single upset does not cascade.
                if (q_fb != exp_state_q) begin
                    mismatch_d  = 1'b1;
                    exp_state_d = q_fb;
                end
                cmd_count_d = cmd_count_q + 8'd1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            exp_state_q <= 1'b0;
            mismatch_q  <= 1'b0;
            cmd_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            j_q         <= j_d;
            k_q         <= k_d;
            exp_state_q <= exp_state_d;
            mismatch_q  <= mismatch_d;
            cmd_count_q <= cmd_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd;
        end
        cur_cmd_q <= cur_cmd_d;
    end

    assign cmd_ready = !full;
    assign j         = j_q;
    assign k         = k_q;
    assign exp_q     = exp_state_q;
    assign mismatch  = mismatch_q;
    assign busy      = !empty || (state_q != S_IDLE);
    assign cmd_count = cmd_count_q;

    a_single_pulse: assert property (@(posedge clk) disable iff (rst)
        (j_q || k_q) |=> !(j_q || k_q));
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer with a behavioural JK flip-flop on the feedback path.
module tb_jk_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_ready;
    logic       j;
    logic       k;
    logic       q_fb;
    logic       exp_q;
    logic       mismatch;
    logic       busy;
    logic [7:0] cmd_count;

    logic q_model = 1'b0;
    logic force_zero = 1'b0;

    typedef struct packed {
        logic       e;
        logic       m;
        logic [7:0] c;
    } comp_t;

    comp_t      comp_q [$];
    logic [1:0] pulse_q [$];
    int         pulse_cyc [$];

    int checks = 0;
    int fail_cnt = 0;
    int cyc = 0;
    int accepts = 0;
    int pulses_seen = 0;
    int toggle_pulses = 0;
    bit ready_low_seen = 0;
    int full_at = -1;

    logic       exp_t = 1'b0;
    logic       mm_t = 1'b0;
    logic [7:0] cnt_t = 8'd0;

    logic [7:0] last_cnt = 8'd0;
    logic       prev_pulse = 1'b0;

    jk_cmd_sequencer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .exp_q     (exp_q),
        .mismatch  (mismatch),
        .busy      (busy),
        .cmd_count (cmd_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream JK flip-flop
    always @(posedge clk or posedge rst) begin
        if (rst) q_model <= 1'b0;
        else begin
            case ({j, k})
                2'b10:   q_model <= 1'b1;
                2'b01:   q_model <= 1'b0;
                2'b11:   q_model <= ~q_model;
                default: q_model <= q_model;
            endcase
        end
    end

    assign q_fb = force_zero ? 1'b0 : q_model;

    // Monitor: pulses and completions are popped from the scoreboard as they appear.
    always @(negedge clk) begin
        if (rst) begin
            last_cnt   = 8'd0;
            prev_pulse = 1'b0;
        end else begin
            if (j || k) begin
                checks++;
                if (prev_pulse) begin
                    fail_cnt++;
                    $display("FAIL jk_consecutive actual=1 required=0 at cycle %0d", cyc);
                end
                checks++;
                if (pulse_q.size() == 0) begin
                    fail_cnt++;
                    $display("FAIL pulse_unexpected actual jk=%0b%0b required=none", j, k);
                end else begin
                    logic [1:0] p;
                    p = pulse_q.pop_front();
                    if ({j, k} !== p) begin
                        fail_cnt++;
                        $display("FAIL pulse_jk actual=%0b%0b required=%0b", j, k, p);
                    end
                end
                pulse_cyc.push_back(cyc);
                pulses_seen++;
                if (j && k) toggle_pulses++;
            end
            prev_pulse = j || k;
            if (cmd_count != last_cnt) begin
                checks++;
                if (comp_q.size() == 0) begin
                    fail_cnt++;
                    $display("FAIL completion_unexpected actual cmd_count=%0d required=%0d", cmd_count, last_cnt);
                end else begin
                    comp_t x;
                    x = comp_q.pop_front();
                    if (exp_q !== x.e || mismatch !== x.m || cmd_count !== x.c) begin
                        fail_cnt++;
                        $display("FAIL completion actual exp_q=%0b mismatch=%0b cmd_count=%0d required exp_q=%0b mismatch=%0b cmd_count=%0d",
                                 exp_q, mismatch, cmd_count, x.e, x.m, x.c);
                    end
                end
                last_cnt = cmd_count;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            fail_cnt++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic send(input logic [1:0] c, input bit bad);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            if (!ready_low_seen) begin
                ready_low_seen = 1;
                full_at = accepts;
            end
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("send_ready_timeout", int'(cmd_ready), 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd = c;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        accepts++;
        case (c)
            2'b01:   exp_t = 1'b0;
            2'b10:   exp_t = 1'b1;
            2'b11:   exp_t = ~exp_t;
            default: exp_t = exp_t;
        endcase
        if (bad) begin
            exp_t = 1'b0;
            mm_t  = 1'b1;
        end
        cnt_t = cnt_t + 8'd1;
        comp_q.push_back('{e: exp_t, m: mm_t, c: cnt_t});
        if (c != 2'b00) pulse_q.push_back(c);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((comp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", int'(n < 300), 1);
        chk("pulse_queue_empty", pulse_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_p;
        int base_acc;
        int base_tog;
        int p0;
        int n;

        // Reset state, checked before any clock edge has been taken out of reset
        #1 rst = 1'b1;
        #7;
        chk("rst_j", int'(j), 0);
        chk("rst_k", int'(k), 0);
        chk("rst_exp_q", int'(exp_q), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_count", int'(cmd_count), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        #3 rst = 1'b0;

        // Single set: pulse one cycle after acceptance, check two cycles later
        send(2'b10, 0);
        @(negedge clk);
        chk("set_j_before", int'(j), 0);
        @(negedge clk);
        chk("set_jk_pulse", int'({j, k}), 2);
        @(negedge clk);
        chk("set_jk_after", int'({j, k}), 0);
        chk("set_q_fb", int'(q_fb), 1);
        @(negedge clk);
        chk("set_cmd_count", int'(cmd_count), 1);
        chk("set_exp_q", int'(exp_q), 1);
        chk("set_mismatch", int'(mismatch), 0);
        wait_drain();
        chk("idle_busy", int'(busy), 0);

        // hold, set, reset, toggle, toggle back-to-back
        base_p = pulse_cyc.size();
        send(2'b00, 0);
        send(2'b10, 0);
        send(2'b01, 0);
        send(2'b11, 0);
        send(2'b11, 0);
        wait_drain();
        chk("seq_exp_q", int'(exp_q), 0);
        chk("seq_cmd_count", int'(cmd_count), 6);
        chk("seq_mismatch", int'(mismatch), 0);
        chk("seq_pulses", pulse_cyc.size() - base_p, 4);
        if (pulse_cyc.size() - base_p == 4) begin
            for (int i = 1; i < 4; i++) begin
                chk("seq_pulse_spacing", pulse_cyc[base_p + i] - pulse_cyc[base_p + i - 1], 3);
            end
        end

        // Full FIFO: toggles offered every cycle
        base_acc = accepts;
        base_tog = toggle_pulses;
        ready_low_seen = 0;
        full_at = -1;
        for (int i = 0; i < 10; i++) send(2'b11, 0);
        wait_drain();
        chk("full_ready_dropped", int'(ready_low_seen), 1);
        chk("full_accepts_before_full", full_at - base_acc, 6);
        chk("full_toggles_eq_accepts", toggle_pulses - base_tog, accepts - base_acc);
        chk("full_exp_q", int'(exp_q), 0);
        chk("full_cmd_count", int'(cmd_count), 16);

        // Forced mismatch on a set, then a clean set
        force_zero = 1'b1;
        send(2'b10, 1);
        wait_drain();
        force_zero = 1'b0;
        chk("mm_flag", int'(mismatch), 1);
        chk("mm_exp_resync", int'(exp_q), 0);
        send(2'b10, 0);
        wait_drain();
        chk("mm_sticky", int'(mismatch), 1);
        chk("mm_clean_exp_q", int'(exp_q), 1);

        // Reset while j is high
        send(2'b10, 0);
        send(2'b10, 0);
        send(2'b10, 0);
        n = 0;
        @(negedge clk);
        while (!j && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("middrive_j_seen", int'(j), 1);
        #2 rst = 1'b1;
        #1;
        chk("middrive_j", int'(j), 0);
        chk("middrive_k", int'(k), 0);
        chk("middrive_busy", int'(busy), 0);
        chk("middrive_cmd_ready", int'(cmd_ready), 1);
        chk("middrive_cmd_count", int'(cmd_count), 0);
        chk("middrive_mismatch", int'(mismatch), 0);
        comp_q.delete();
        pulse_q.delete();
        exp_t = 1'b0;
        mm_t  = 1'b0;
        cnt_t = 8'd0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        p0 = pulses_seen;
        repeat (20) @(negedge clk);
        chk("middrive_no_replay", pulses_seen - p0, 0);
        chk("middrive_busy_after", int'(busy), 0);
        chk("middrive_count_after", int'(cmd_count), 0);

        // 256 holds wrap the counter back to 0
        for (int i = 0; i < 256; i++) send(2'b00, 0);
        wait_drain();
        chk("wrap_cmd_count", int'(cmd_count), 0);
        chk("wrap_exp_q", int'(exp_q), 0);
        chk("wrap_mismatch", int'(mismatch), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fail_cnt);
        $finish;
    end

endmodule
